// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants and entry type for the fetch-to-decode queue
package if_id_queue_pkg;
  localparam int IFQ_DEPTH = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: unreset register array, synchronous write, asynchronous read
module ifq_storage
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [PTR_W-1:0] raddr,
  output entry_t           rdata
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction queue between fetch and decode with redirect flush
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_fault,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_fault,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  entry_t           head;
  assign in_ready  = rst && (count_q != (PTR_W+1)'(DEPTH));
  assign out_valid = rst && (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_fault = out_valid && head.fault;
  always_comb begin
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
    count_d  = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata('{pc: in_pc, inst: in_inst, fault: in_fault}),
    .raddr(rd_ptr_q),
    .rdata(head)
  );
  a_pow2:     assert property (@(posedge clk) (DEPTH & (DEPTH - 1)) == 0);
  a_count:    assert property (@(posedge clk) disable iff (!rst) count_q <= (PTR_W+1)'(DEPTH));
  a_push_rdy: assert property (@(posedge clk) disable iff (!rst) push |-> in_ready);
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed checks of if_id_queue against a queue model
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_fault = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid, out_fault;
  logic [31:0] out_pc, out_inst;
  logic [2:0] count;
  int errors = 0, checks = 0;
  logic [64:0] q [$];
  always #5 clk = ~clk;
  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_fault(in_fault), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .count(count)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic f, input logic fl, input logic ordy);
    logic [64:0] head;
    logic do_push, do_pop;
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst; in_fault = f; flush = fl; out_ready = ordy;
    #3;
    head = (r && q.size() > 0) ? q[0] : 65'd0;
    check("in_ready", 64'(in_ready), 64'(r && q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(r && q.size() > 0));
    check("out_pc", 64'(out_pc), 64'(head[64:33]));
    check("out_inst", 64'(out_inst), 64'(head[32:1]));
    check("out_fault", 64'(out_fault), 64'(head[0]));
    check("count", 64'(count), 64'(q.size()));
    do_push = r && !fl && iv && q.size() < DEPTH;
    do_pop = r && !fl && ordy && q.size() > 0;
    @(posedge clk);
    if (!r || fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({pc, inst, f});
    end
    #1;
  endtask
  task automatic idle(input logic ordy);
    cyc(1, 0, 32'h0, 32'h0, 0, 0, ordy);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 1, 32'h11111111, 32'h1, 0, 0, 1);
    cyc(1, 1, 32'h80000000, 32'h00000413, 0, 0, 0);
    idle(0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'h80000000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(1);
    idle(0);
    cyc(1, 1, 32'h90000000, 32'h200, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc(1, 1, 32'h90000000 + 32'(4 * i), 32'h200 + 32'(i), 0, 0, 1);
    idle(0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 32'hA0000000 + 32'(4 * i), 32'h300 + 32'(i), 0, 0, 0);
    cyc(1, 1, 32'hBADBAD00, 32'hBAD, 0, 1, 1);
    idle(1);
    cyc(1, 1, 32'hC0000000, 32'hDEADBEEF, 1, 0, 0);
    cyc(1, 1, 32'hC0000004, 32'h00000013, 0, 0, 0);
    idle(1);
    idle(1);
    idle(0);
    cyc(1, 1, 32'hD0000000, 32'h400, 0, 0, 0);
    cyc(1, 1, 32'hD0000004, 32'h401, 0, 0, 0);
    cyc(0, 1, 32'hD0000008, 32'h402, 0, 0, 1);
    idle(0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(49) != 0, $urandom_range(9) < 6, $urandom, $urandom,
          $urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(1) == 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
